// File: rtl/mips_muldiv_ctrl.sv
// HI/LO owner: iterative shift-add multiply / restoring divide, WIDTH+1 busy cycles per op (done in the last).
// New requests wait on op_ready (IDLE only); stall holds the pipeline for MF reads or new ops while busy.
module mips_muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             op_ready,
  output logic             busy,
  output logic             done,
  input  logic             mf_req,
  input  logic             mf_sel,
  output logic [WIDTH-1:0] mf_data,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic               is_div, neg_q, neg_r;
  logic [WIDTH-1:0]   opb, acc_hi, acc_lo;
  logic               accept, start_md, sign_a, sign_b;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] prod, prod_fix;

  assign accept   = op_valid && op_ready;
  assign start_md = accept && !op[2];
  // even op codes (MULT, DIV) are the signed variants
  assign sign_a   = !op[0] && src_a[WIDTH-1];
  assign sign_b   = !op[0] && src_b[WIDTH-1];
  assign abs_a    = sign_a ? -src_a : src_a;
  assign abs_b    = sign_b ? -src_b : src_b;

  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, opb};
  // the partial remainder after a successful subtract is below the divisor, so WIDTH bits suffice
  assign div_rem   = div_shift[WIDTH-1:0] - opb;
  assign prod      = {acc_hi, acc_lo};
  assign prod_fix  = neg_q ? -prod : prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_md) state_nxt = RUN;
      RUN:     if (cnt == CW'(1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    op_ready = (state == IDLE);
    busy     = (state != IDLE);
    done     = (state == FIX);
  end

  assign stall   = busy && (mf_req || op_valid);
  assign mf_data = mf_sel ? hi : lo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      opb    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_md) begin
            cnt    <= CW'(WIDTH);
            is_div <= op[1];
            opb    <= op[1] ? abs_b : abs_a;
            acc_hi <= '0;
            acc_lo <= op[1] ? abs_a : abs_b;
            // divide by zero keeps the all-ones quotient unsigned; the remainder restores src_a
            neg_q  <= (sign_a ^ sign_b) && !(op[1] && (src_b == '0));
            neg_r  <= sign_a;
          end else if (accept && (op == 3'd4)) begin
            hi <= src_a;
          end else if (accept && (op == 3'd5)) begin
            lo <= src_a;
          end
        end
        RUN: begin
          cnt <= cnt - CW'(1);
          if (is_div) begin
            acc_hi <= div_ge ? div_rem : div_shift[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
          end else begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end
        end
        FIX: begin
          if (is_div) begin
            lo <= neg_q ? -acc_lo : acc_lo;
            hi <= neg_r ? -acc_hi : acc_hi;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mips_muldiv_ctrl.md
Name: mips_muldiv_ctrl

Overview:
Multi-cycle multiply/divide sequencer that owns the HI/LO register pair for the MIPS core. It takes MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from the ALU decode stage and runs an iterative radix-2 shift-add multiply or restoring divide. It stalls the pipeline when MFHI/MFLO or a new mul/div arrives while an operation is in flight. It replaces single-cycle HI/LO arithmetic inside the ALU.

Parameters:
WIDTH, 32, operand width; iteration count equals WIDTH.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
op_valid  in  1  request valid
op  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6-7 reserved (ignored)
src_a  in  WIDTH  multiplicand / dividend / MTHI-MTLO data
src_b  in  WIDTH  multiplier / divisor
op_ready  out  1  request accepted this cycle when op_valid && op_ready
busy  out  1  iteration in progress
done  out  1  one-cycle pulse when HI/LO are written by mul/div
mf_req  in  1  MFHI/MFLO read request
mf_sel  in  1  0=LO, 1=HI
mf_data  out  WIDTH  combinational mux of HI/LO registers
stall  out  1  pipeline hold
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (async, rst_n=0): state IDLE, hi=lo=0, busy=0, done=0, iteration counter=0, internal accumulators=0. op_ready=1 after release.
- op_ready = (state==IDLE). stall = busy && (mf_req || op_valid).
- FSM states:
  - IDLE: on an accepted MULT/MULTU/DIV/DIVU, latch operands and go to RUN. Signed ops latch absolute values plus result-sign flags. Counter loads WIDTH.
  - RUN: one partial product, or one restore-subtract step, per cycle. The counter decrements; go to FIX when the counter reaches 1.
  - FIX: apply sign correction, write hi/lo, done=1, go to IDLE.
- Timing: accepted at edge k. busy=1 in cycles k+1 .. k+WIDTH+1 (WIDTH+1 cycles). done=1 in cycle k+WIDTH+1. New hi/lo visible from cycle k+WIDTH+2. Back-to-back: the next op may be accepted in cycle k+WIDTH+2.
- MTHI/MTLO: accepted only in IDLE. Writes hi or lo at the accepting edge; no busy, no done.
- Requests while busy: op_ready=0 and the op is not latched. The requester holds op_valid until accepted.
- Multiply results:
  - MULTU: {hi,lo} = zero-extended product, 2*WIDTH bits.
  - MULT: two's-complement product; negate if sign(a) xor sign(b).
- Divide results:
  - DIVU: lo = quotient, hi = remainder.
  - DIV: truncating toward zero. Quotient negated if the signs differ. Remainder takes the sign of the dividend.
  - Most-negative / -1: lo = 0x80000000, hi = 0 (wraps, no trap).
- Divide by zero (src_b==0): still takes the full WIDTH+1 cycles. lo = all ones, hi = src_a as latched (signed or unsigned identical).
- mf_data reflects hi/lo registers only. During busy the data is stale; the consumer must honour stall.
- Reserved op codes: accepted (op_ready handshake completes) but no state change.
- Reset mid-RUN: immediate abort to IDLE, hi=lo=0, no done pulse.

Test Plan:
- DIVU src_a=0x11111111, src_b=0x88 -> done at cycle k+33; lo=0x00202020, hi=0x00000011; busy high exactly 33 cycles.
- MULTU src_a=0x11111111, src_b=0x88 -> hi=0x00000009, lo=0x11111108.
- Signed DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. MULT -3*5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MFHI (mf_req=1, mf_sel=1) asserted during RUN -> stall=1 until cycle k+WIDTH+2, then mf_data=new hi. Second MULT held with op_valid during RUN -> op_ready=0, accepted the cycle after done.
- DIVU by 0 with src_a=0x1234 -> lo=0xFFFFFFFF, hi=0x00001234. MTHI 0xA5A5A5A5 in IDLE -> hi updates next edge, busy stays 0.
- rst_n pulsed low mid-RUN (cycle k+10) -> busy=0, hi=lo=0 immediately, no done; a new MULTU after release completes normally.
